// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw button pins in, debounced levels and
// press/release strobes out. The master drives the pins; the conditioner is the slave.
interface button_conditioner_if;
  logic button1;
  logic button2;
  logic btn1_level;
  logic btn2_level;
  logic btn1_press;
  logic btn2_press;
  logic btn1_release;
  logic btn2_release;

  modport master (
    output button1, button2,
    input  btn1_level, btn2_level, btn1_press, btn2_press, btn1_release, btn2_release
  );

  modport slave (
    input  button1, button2,
    output btn1_level, btn2_level, btn1_press, btn2_press, btn1_release, btn2_release
  );
endinterface

// File: rtl/button_conditioner.sv
// Two independent button channels. Each channel is a 2-FF synchronizer, then a
// debounce counter, then registered level and one-cycle press/release strobes.
// Define BTN_AUTOREPEAT_EN to make a held button re-fire presses.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input logic                  clk,
  input logic                  reset,
  button_conditioner_if.slave  bus
);

  localparam int unsigned CW_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    raw;
  logic [1:0]    s1_q, s2_q;
  logic [1:0]    lvl_q, lvl_d;
  logic [1:0]    press_q, press_d;
  logic [1:0]    release_q, release_d;
  logic [1:0]    rise, fall;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // Gather the raw pins into a per-channel vector
  always_comb begin
    raw = {bus.button2, bus.button1};
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      lvl_d[ch] = lvl_q[ch];
      cnt_d[ch] = '0;
      if (s2_q[ch] != lvl_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          lvl_d[ch] = s2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
    rise = lvl_d & ~lvl_q;
    fall = ~lvl_d & lvl_q;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW_RAW = $clog2(RMAX);
  localparam int unsigned RW     = (RW_RAW < 1) ? 1 : RW_RAW;
  localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_e;

  rep_state_e    state_q [2];
  rep_state_e    state_d [2];
  logic [RW-1:0] rcnt_q  [2];
  logic [RW-1:0] rcnt_d  [2];
  logic [1:0]    rep;

  // Repeat FSM: a fall always wins, so no repeat press can share a cycle with release
  always_comb begin
    rep = '0;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      rcnt_d[ch]  = rcnt_q[ch];
      if (fall[ch]) begin
        state_d[ch] = ST_IDLE;
        rcnt_d[ch]  = '0;
      end else if (rise[ch]) begin
        state_d[ch] = ST_DELAY;
        rcnt_d[ch]  = '0;
      end else begin
        case (state_q[ch])
          ST_DELAY: begin
            if (rcnt_q[ch] == DELAY_MAX) begin
              rep[ch]     = 1'b1;
              state_d[ch] = ST_REPEAT;
              rcnt_d[ch]  = '0;
            end else begin
              rcnt_d[ch] = rcnt_q[ch] + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (rcnt_q[ch] == PERIOD_MAX) begin
              rep[ch]    = 1'b1;
              rcnt_d[ch] = '0;
            end else begin
              rcnt_d[ch] = rcnt_q[ch] + RW'(1);
            end
          end
          default: begin
            state_d[ch] = ST_IDLE;
            rcnt_d[ch]  = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ST_IDLE;
        rcnt_q[ch]  <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        rcnt_q[ch]  <= rcnt_d[ch];
      end
    end
  end

  // Strobes: press on debounced rise or repeat tick, release on debounced fall
  always_comb begin
    press_d   = rise | rep;
    release_d = fall;
  end
`else
  // Strobes: exactly one press per debounced rise, one release per fall
  always_comb begin
    press_d   = rise;
    release_d = fall;
  end
`endif

  // Synchronizer, debounce and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign bus.btn1_level   = lvl_q[0];
  assign bus.btn2_level   = lvl_q[1];
  assign bus.btn1_press   = press_q[0];
  assign bus.btn2_press   = press_q[1];
  assign bus.btn1_release = release_q[0];
  assign bus.btn2_release = release_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3. Edge numbers count rising edges after
// the stimulus change; outputs are sampled 1 ns after each rising edge.
module tb_button_conditioner;

  logic clk;
  logic reset;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int edge_n;
  int p1_cnt, p2_cnt, r1_cnt, r2_cnt;
  int p1_first, p2_first, p2_second, r1_first, r2_first;
  int p2_late, clash;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    edge_n    = 0;
    p1_cnt    = 0; p2_cnt   = 0; r1_cnt = 0; r2_cnt = 0;
    p1_first  = 0; p2_first = 0; p2_second = 0;
    r1_first  = 0; r2_first = 0;
    p2_late   = 0; clash    = 0;
  endtask

  function automatic int outs();
    return int'({bif.btn2_release, bif.btn2_press, bif.btn2_level,
                 bif.btn1_release, bif.btn1_press, bif.btn1_level});
  endfunction

  // Advance one clock and record strobe activity seen after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (bif.btn1_press) begin
      p1_cnt++;
      if (p1_first == 0) p1_first = edge_n;
    end
    if (bif.btn2_press) begin
      p2_cnt++;
      if (r2_first != 0) p2_late++;
      if (p2_first == 0) p2_first = edge_n;
      else if (p2_second == 0) p2_second = edge_n;
    end
    if (bif.btn1_release) begin
      r1_cnt++;
      if (r1_first == 0) r1_first = edge_n;
    end
    if (bif.btn2_release) begin
      r2_cnt++;
      if (r2_first == 0) r2_first = edge_n;
    end
    if ((bif.btn1_press && bif.btn1_release) || (bif.btn2_press && bif.btn2_release)) clash++;
  endtask

  initial begin
    reset       = 1'b0;
    bif.button1 = 1'b0;
    bif.button2 = 1'b0;
    clear_obs();

    // Reset held low for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    reset = 1'b1;
    repeat (20) tick();
    check("idle_strobes", p1_cnt + p2_cnt + r1_cnt + r2_cnt, 0);
    check("idle_outs", outs(), 0);

    // Clean single press on button1
    clear_obs();
    bif.button1 = 1'b1;
    repeat (5) tick();
    check("b1_lvl_e5", int'(bif.btn1_level), 0);
    repeat (5) tick();
    check("b1_press_edge", p1_first, 6);
    check("b1_press_cnt", p1_cnt, 1);
    check("b1_lvl_held", int'(bif.btn1_level), 1);
    check("b2_quiet", p2_cnt + r2_cnt + int'(bif.btn2_level), 0);
    clear_obs();
    bif.button1 = 1'b0;
    repeat (10) tick();
    check("b1_rel_edge", r1_first, 6);
    check("b1_rel_cnt", r1_cnt, 1);
    check("b1_no_press_on_fall", p1_cnt, 0);

    // Bounce 1,0,1 in 2-cycle phases, hold, then release
    clear_obs();
    bif.button1 = 1'b1;
    repeat (2) tick();
    bif.button1 = 1'b0;
    repeat (2) tick();
    bif.button1 = 1'b1;
    repeat (10) tick();
    check("bounce_press_edge", p1_first, 10);
    check("bounce_press_cnt", p1_cnt, 1);
    bif.button1 = 1'b0;
    repeat (12) tick();
    check("bounce_rel_edge", r1_first, 20);
    check("bounce_rel_cnt", r1_cnt, 1);
    check("bounce_press_total", p1_cnt, 1);
    check("bounce_clash", clash, 0);

    // Both buttons rise together, then fall together
    clear_obs();
    bif.button1 = 1'b1;
    bif.button2 = 1'b1;
    repeat (10) tick();
    check("both_p1_edge", p1_first, 6);
    check("both_p2_edge", p2_first, 6);
    clear_obs();
    bif.button1 = 1'b0;
    bif.button2 = 1'b0;
    repeat (10) tick();
    check("both_r1_edge", r1_first, 6);
    check("both_r2_edge", r2_first, 6);

    // Reset asserted with the debounce count at 2
    clear_obs();
    bif.button1 = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("midrst_outs", outs(), 0);
    repeat (3) tick();
    check("midrst_no_press", p1_cnt, 0);
    check("midrst_outs_held", outs(), 0);
    reset = 1'b1;
    clear_obs();
    repeat (10) tick();
    check("postrst_press_edge", p1_first, 6);
    check("postrst_press_cnt", p1_cnt, 1);
    bif.button1 = 1'b0;
    repeat (10) tick();

    // Long hold on button2, then release
    clear_obs();
    bif.button2 = 1'b1;
    repeat (30) tick();
    bif.button2 = 1'b0;
    repeat (15) tick();
    check("hold_first_press", p2_first, 6);
`ifdef BTN_AUTOREPEAT_EN
    check("hold_second_press", p2_second, 14);
    check("hold_press_cnt", p2_cnt, 9);
`else
    check("hold_second_press", p2_second, 0);
    check("hold_press_cnt", p2_cnt, 1);
`endif
    check("hold_rel_edge", r2_first, 36);
    check("hold_rel_cnt", r2_cnt, 1);
    check("hold_press_after_rel", p2_late, 0);
    check("hold_b1_quiet", p1_cnt + r1_cnt, 0);
    check("hold_clash", clash, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
